// File: rtl/reverse_bits.sv
// reverse_bits: dual-channel word reverser at bit, pair or nibble granularity, with registered copies
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset (clears registered path only)
//   mode      00 bits, 01 2-bit pairs, 10 nibbles, 11 pass-through
//   in_valid  capture enable for q_reg/w_reg
//   a, b      channel data
//   q, w      combinational transform of a, b
//   q_reg     registered transform of a
//   w_reg     registered transform of b
//   out_valid q_reg/w_reg were captured on the previous edge
module reverse_bits #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       mode,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] w,
   output logic [WIDTH-1:0] q_reg,
   output logic [WIDTH-1:0] w_reg,
   output logic             out_valid
);
   if ((WIDTH < 8) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
      $error("reverse_bits: WIDTH must be a power of two and at least 8");
   end
   // Group k of the result takes group N-1-k of the input; bit order inside a group is kept.
   function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] x, input logic [1:0] m);
      logic [WIDTH-1:0] r1, r2, r4;
      r1 = '0;
      r2 = '0;
      r4 = '0;
      for (int i = 0; i < WIDTH; i++) r1[WIDTH-1-i] = x[i];
      for (int i = 0; i < WIDTH/2; i++) r2[2*(WIDTH/2-1-i) +: 2] = x[2*i +: 2];
      for (int i = 0; i < WIDTH/4; i++) r4[4*(WIDTH/4-1-i) +: 4] = x[4*i +: 4];
      return m == 2'b00 ? r1 : m == 2'b01 ? r2 : m == 2'b10 ? r4 : x;
   endfunction
   logic [WIDTH-1:0] q_reg_q, q_reg_d, w_reg_q, w_reg_d;
   logic             out_valid_q, out_valid_d;
   assign q = xform(a, mode);
   assign w = xform(b, mode);
   always_comb begin
      q_reg_d     = in_valid ? q : q_reg_q;
      w_reg_d     = in_valid ? w : w_reg_q;
      out_valid_d = in_valid;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg_q     <= '0;
         w_reg_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         q_reg_q     <= q_reg_d;
         w_reg_q     <= w_reg_d;
         out_valid_q <= out_valid_d;
      end
   end
   assign q_reg     = q_reg_q;
   assign w_reg     = w_reg_q;
   assign out_valid = out_valid_q;
endmodule

// File: tb/tb_reverse_bits.sv
// tb_reverse_bits: table-driven, random and reset-sequence checks of reverse_bits
module tb_reverse_bits;
   localparam int W = 8;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic [W-1:0] q, w, q_reg, w_reg;
   logic         out_valid;
   int           total = 0;
   int           passed = 0;

   reverse_bits #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
      .a(a), .b(b), .q(q), .w(w), .q_reg(q_reg), .w_reg(w_reg), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference: output bit j lies in group j/G at offset j%G and comes from group N-1-(j/G).
   function automatic logic [W-1:0] ref_t(input logic [W-1:0] x, input logic [1:0] m);
      int g, n;
      logic [W-1:0] r;
      g = (m == 2'b11) ? W : (1 << m);
      n = W / g;
      for (int j = 0; j < W; j++) r[j] = x[(n - 1 - j / g) * g + j % g];
      return r;
   endfunction

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [1:0]   m;
      logic [W-1:0] va, vb, eq, ew;
   } vec_t;

   initial begin
      vec_t vecs[6];
      logic [W-1:0] eq, ew;
      logic         iv;
      vecs[0] = '{2'b00, 8'b1100_0010, 8'h01, 8'b0100_0011, 8'h80};
      vecs[1] = '{2'b01, 8'hE4, 8'h1B, 8'h1B, 8'hE4};
      vecs[2] = '{2'b10, 8'h3C, 8'h12, 8'hC3, 8'h21};
      vecs[3] = '{2'b11, 8'h5A, 8'h96, 8'h5A, 8'h96};
      vecs[4] = '{2'b00, 8'hFF, 8'h00, 8'hFF, 8'h00};
      vecs[5] = '{2'b01, 8'h80, 8'h01, 8'h02, 8'h40};

      // reset state, combinational path live during reset
      a = 8'h01; b = 8'hC2;
      #2;
      check("rst_q_reg", q_reg, 8'h00);
      check("rst_w_reg", w_reg, 8'h00);
      check("rst_out_valid", {7'b0, out_valid}, 8'h00);
      check("rst_q_comb", q, 8'h80);
      check("rst_w_comb", w, 8'h43);
      in_valid = 1'b1;
      step();
      check("rst_hold_out_valid", {7'b0, out_valid}, 8'h00);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // table vectors
      for (int i = 0; i < 6; i++) begin
         mode = vecs[i].m; a = vecs[i].va; b = vecs[i].vb; in_valid = 1'b1;
         #1;
         check($sformatf("vec%0d_q", i), q, vecs[i].eq);
         check($sformatf("vec%0d_w", i), w, vecs[i].ew);
         step();
         check($sformatf("vec%0d_q_reg", i), q_reg, vecs[i].eq);
         check($sformatf("vec%0d_w_reg", i), w_reg, vecs[i].ew);
         check($sformatf("vec%0d_out_valid", i), {7'b0, out_valid}, 8'h01);
      end

      // random stimulus per mode against the reference model
      eq = q_reg; ew = w_reg;
      for (int m = 0; m < 4; m++) begin
         for (int c = 0; c < 8; c++) begin
            mode = 2'(m); a = W'($urandom); b = W'($urandom); iv = 1'($urandom);
            in_valid = iv;
            #1;
            check("rnd_q", q, ref_t(a, mode));
            check("rnd_w", w, ref_t(b, mode));
            check("rnd_invol_q", ref_t(q, mode), a);
            check("rnd_invol_w", ref_t(w, mode), b);
            if (iv) begin
               eq = ref_t(a, mode);
               ew = ref_t(b, mode);
            end
            step();
            check("rnd_q_reg", q_reg, eq);
            check("rnd_w_reg", w_reg, ew);
            check("rnd_out_valid", {7'b0, out_valid}, {7'b0, iv});
         end
      end

      // in_valid 1,0,1 with mode 00
      mode = 2'b00;
      a = 8'h01; b = 8'h01; in_valid = 1'b1; step();
      check("seq1_q_reg", q_reg, 8'h80);
      check("seq1_out_valid", {7'b0, out_valid}, 8'h01);
      a = 8'hFF; b = 8'hFF; in_valid = 1'b0; step();
      check("seq2_q_reg", q_reg, 8'h80);
      check("seq2_out_valid", {7'b0, out_valid}, 8'h00);
      a = 8'h80; b = 8'h80; in_valid = 1'b1; step();
      check("seq3_q_reg", q_reg, 8'h01);
      check("seq3_out_valid", {7'b0, out_valid}, 8'h01);

      // mid-stream asynchronous reset between edges
      a = 8'hC2; b = 8'h0F; in_valid = 1'b1; step();
      check("pre_rst_out_valid", {7'b0, out_valid}, 8'h01);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_q_reg", q_reg, 8'h00);
      check("async_rst_w_reg", w_reg, 8'h00);
      check("async_rst_out_valid", {7'b0, out_valid}, 8'h00);
      a = 8'h12; mode = 2'b10;
      #1;
      check("async_rst_q_comb", q, 8'h21);
      check("async_rst_w_comb", w, 8'hF0);
      step();
      check("rst_low_q_reg", q_reg, 8'h00);
      check("rst_low_out_valid", {7'b0, out_valid}, 8'h00);

      // release with in_valid low, then first capture
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("rel_out_valid", {7'b0, out_valid}, 8'h00);
      check("rel_q_reg", q_reg, 8'h00);
      mode = 2'b00; a = 8'hC2; b = 8'h01; in_valid = 1'b1;
      step();
      check("first_cap_out_valid", {7'b0, out_valid}, 8'h01);
      check("first_cap_q_reg", q_reg, 8'h43);
      check("first_cap_w_reg", w_reg, 8'h80);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/reverse_bits.md
Name: reverse_bits

Overview:
- Dual-channel bit-order reverser. Two independent WIDTH-bit words (a, b) are reordered at a selectable granularity.
- Each channel has a combinational result (q, w) and a registered copy (q_reg, w_reg) with a valid flag.
- Used as a datapath utility wherever LSB-first/MSB-first conversion or group swapping is needed.

Parameters:
- WIDTH, 8, data width of each channel; must be a power of two and at least 8.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  reversal granularity: 00 bits, 01 2-bit pairs, 10 4-bit nibbles, 11 pass-through.
- in_valid  input  1  capture enable for the registered path.
- a  input  WIDTH  channel A data.
- b  input  WIDTH  channel B data.
- q  output  WIDTH  combinational transform of a.
- w  output  WIDTH  combinational transform of b.
- q_reg  output  WIDTH  registered transform of a.
- w_reg  output  WIDTH  registered transform of b.
- out_valid  output  1  q_reg/w_reg hold a capture from the previous edge.

Behaviour:
- One clock (clk); reset rst_n is asynchronous and active-low.
- Transform T(x, mode), with G = group size (1, 2, 4) and N = WIDTH/G groups:
  - Result group k = input group N-1-k. Bit order inside each group is preserved.
  - mode 00 is a full bit reversal: out[WIDTH-1-i] = x[i].
  - mode 11 gives out = x.
- T is an involution for every mode: T(T(x)) = x.
- Combinational path:
  - q = T(a, mode), w = T(b, mode), zero latency, no clock dependence.
  - Valid during reset as well; reset does not affect q/w.
  - Both channels always use the same mode.
- Registered path, rising clk edge with in_valid=1:
  - q_reg <= T(a, mode), w_reg <= T(b, mode), out_valid <= 1.
  - mode, a and b are sampled at that edge.
- Rising edge with in_valid=0: q_reg/w_reg hold their values; out_valid <= 0.
- Registered latency is exactly 1 cycle; back-to-back captures are supported at full rate.
- Reset (rst_n=0):
  - q_reg=0, w_reg=0, out_valid=0 immediately, with no wait for a clock edge.
  - Registers stay cleared while rst_n is low.
  - First capture happens on the first rising edge with rst_n=1 and in_valid=1.
- Reset asserted mid-stream discards the pending result; no stale out_valid after release.
- mode change between edges affects only the combinational outputs until the next capture.
- X/Z on inputs is not filtered; outputs follow normal RTL propagation.
- No handshake back-pressure; the block always accepts data.

Test Plan:
- mode=00, a=8'b1100_0010, b=8'h01 -> q=8'b0100_0011, w=8'h80 combinationally; after an edge with in_valid=1: q_reg=8'h43, w_reg=8'h80, out_valid=1.
- mode=01, a=8'hE4, b=8'h1B -> q=8'h1B, w=8'hE4. mode=10, a=8'h3C, b=8'h12 -> q=8'hC3, w=8'h21. mode=11, a=8'h5A -> q=8'h5A.
- Random a/b for 8 cycles, each mode -> q/w equal the reference transform each cycle; applying T to q yields a (involution check).
- in_valid pattern 1,0,1 with a=8'h01, 8'hFF, 8'h80 (mode 00) -> q_reg sequence 8'h80, 8'h80 (held), 8'h01; out_valid sequence 1, 0, 1.
- rst_n pulled low between edges while out_valid=1 -> q_reg=w_reg=0 and out_valid=0 before the next edge; q/w still track a/b.
- Release rst_n with in_valid=0 -> out_valid stays 0; the first edge with in_valid=1 produces out_valid=1 one cycle later.
